// File: rtl/dht11_responder_if.sv
// Payload and status bundle between a DHT11 responder and its controller.
// The i_corrupt_csum member exists only when DHT11_CSUM_INJECT_EN is defined.
interface dht11_responder_if;
  logic [7:0] i_humidity_int;
  logic [7:0] i_humidity_dec;
  logic [7:0] i_temp_int;
  logic [7:0] i_temp_dec;
  logic       o_busy;
  logic       o_frame_done;

`ifdef DHT11_CSUM_INJECT_EN
  logic       i_corrupt_csum;

  modport master (
    output i_humidity_int, i_humidity_dec, i_temp_int, i_temp_dec, i_corrupt_csum,
    input  o_busy, o_frame_done
  );

  modport slave (
    input  i_humidity_int, i_humidity_dec, i_temp_int, i_temp_dec, i_corrupt_csum,
    output o_busy, o_frame_done
  );
`else
  modport master (
    output i_humidity_int, i_humidity_dec, i_temp_int, i_temp_dec,
    input  o_busy, o_frame_done
  );

  modport slave (
    input  i_humidity_int, i_humidity_dec, i_temp_int, i_temp_dec,
    output o_busy, o_frame_done
  );
`endif
endinterface

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects the host start pulse, sends the ack and a 40-bit frame.
// Optional macro DHT11_CSUM_INJECT_EN adds i_corrupt_csum, which flips checksum bit 0.
module dht11_responder #(
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30,
  parameter int ACK_LOW_US    = 80,
  parameter int ACK_HIGH_US   = 80,
  parameter int BIT_LOW_US    = 50,
  parameter int ZERO_HIGH_US  = 26,
  parameter int ONE_HIGH_US   = 70
) (
  input  logic             clk1mhz,
  input  logic             rst,
  inout  wire              io_dht11_dat,
  dht11_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REL,
    S_RESP_DELAY,
    S_ACK_LOW,
    S_ACK_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW
  } state_t;

  // Terminal counts: a phase of N cycles ends when cnt reaches N-1.
  localparam logic [15:0] START_LAST = 16'(START_MIN_US - 1);
  localparam logic [15:0] RESP_LAST  = 16'(RESP_DELAY_US - 1);
  localparam logic [15:0] ACKL_LAST  = 16'(ACK_LOW_US - 1);
  localparam logic [15:0] ACKH_LAST  = 16'(ACK_HIGH_US - 1);
  localparam logic [15:0] BITL_LAST  = 16'(BIT_LOW_US - 1);
  localparam logic [15:0] ZERO_LAST  = 16'(ZERO_HIGH_US - 1);
  localparam logic [15:0] ONE_LAST   = 16'(ONE_HIGH_US - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic [39:0] r_shift;
  logic [5:0]  r_bit_cnt;
  logic        r_frame_done;
  logic        w_line_s;
  logic        w_drive_low;
  logic        w_busy;
  logic [7:0]  w_csum;
  logic [7:0]  w_csum_tx;
  logic [15:0] w_high_last;

  assign w_line_s    = r_sync[1];
  assign w_csum      = bus.i_humidity_int + bus.i_humidity_dec + bus.i_temp_int + bus.i_temp_dec;
  assign w_high_last = r_shift[39] ? ONE_LAST : ZERO_LAST;

`ifdef DHT11_CSUM_INJECT_EN
  assign w_csum_tx = w_csum ^ {7'd0, bus.i_corrupt_csum};
`else
  assign w_csum_tx = w_csum;
`endif

  always_ff @(posedge clk1mhz) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sync       <= 2'b11;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], io_dht11_dat};
      r_state      <= w_next;
      r_frame_done <= (r_state == S_END_LOW) && (w_next == S_IDLE);

      if (w_next != r_state || (r_state == S_IDLE && w_line_s))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 16'd1;

      if (r_state == S_WAIT_REL && w_next == S_RESP_DELAY) begin
        r_shift   <= {bus.i_humidity_int, bus.i_humidity_dec, bus.i_temp_int, bus.i_temp_dec, w_csum_tx};
        r_bit_cnt <= '0;
      end else if (r_state == S_BIT_HIGH && w_next != S_BIT_HIGH) begin
        r_shift   <= {r_shift[38:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end
    end
  end

  // The synchronized line is only consulted in states where the line is released.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (!w_line_s && r_cnt == START_LAST) w_next = S_WAIT_REL;
      S_WAIT_REL:   if (w_line_s) w_next = S_RESP_DELAY;
      S_RESP_DELAY: if (r_cnt == RESP_LAST) w_next = S_ACK_LOW;
      S_ACK_LOW:    if (r_cnt == ACKL_LAST) w_next = S_ACK_HIGH;
      S_ACK_HIGH:   if (r_cnt == ACKH_LAST) w_next = S_BIT_LOW;
      S_BIT_LOW:    if (r_cnt == BITL_LAST) w_next = S_BIT_HIGH;
      S_BIT_HIGH:   if (r_cnt == w_high_last) w_next = (r_bit_cnt == 6'd39) ? S_END_LOW : S_BIT_LOW;
      S_END_LOW:    if (r_cnt == BITL_LAST) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_drive_low = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE:                          w_busy      = 1'b0;
      S_ACK_LOW, S_BIT_LOW, S_END_LOW: w_drive_low = 1'b1;
      default:                         ;
    endcase
  end

  assign io_dht11_dat     = w_drive_low ? 1'b0 : 1'bz;
  assign bus.o_busy       = w_busy;
  assign bus.o_frame_done = r_frame_done;

endmodule

// File: tb/tb_dht11_responder.sv
// Host-side bench for dht11_responder: issues start pulses, times every line phase
// and decodes the frame against a payload/checksum reference model.
module tb_dht11_responder;

  localparam int START_MIN  = 2000;
  localparam int SHORT_LOW  = 500;
  localparam int RESP_DELAY = 30;
  localparam int ACK_LOW    = 80;
  localparam int ACK_HIGH   = 80;
  localparam int BIT_LOW    = 50;
  localparam int ZERO_HIGH  = 26;
  localparam int ONE_HIGH   = 70;

  logic clk1mhz = 1'b0;
  logic rst     = 1'b1;
  logic hostLow = 1'b0;
  logic sample;
  wire  dat;

  int checks   = 0;
  int errors   = 0;
  int fdPulses = 0;

  assign dat = hostLow ? 1'b0 : 1'bz;
  pullup (dat);

  dht11_responder_if bus ();

  dht11_responder #(
    .START_MIN_US(START_MIN)
  ) dut (
    .clk1mhz      (clk1mhz),
    .rst          (rst),
    .io_dht11_dat (dat),
    .bus          (bus)
  );

  always #500 clk1mhz = ~clk1mhz;

  always @(posedge clk1mhz) begin
    if (bus.o_frame_done === 1'b1) fdPulses <= fdPulses + 1;
  end

  initial begin
    #(300_000_000);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1mhz);
    #1;
    sample = dat;
  endtask

  task automatic measure(input logic level, input int limit, output int len);
    len = 0;
    while (sample === level && len < limit) begin
      len++;
      step();
    end
  endtask

  task automatic setPayload(input logic [31:0] p);
    bus.i_humidity_int = p[31:24];
    bus.i_humidity_dec = p[23:16];
    bus.i_temp_int     = p[15:8];
    bus.i_temp_dec     = p[7:0];
  endtask

  // Host start pulse: line held low for exactly lowCycles clock edges.
  task automatic applyStimulus(input int lowCycles);
    @(negedge clk1mhz);
    hostLow = 1'b1;
    repeat (lowCycles) @(negedge clk1mhz);
    hostLow = 1'b0;
  endtask

  function automatic logic [39:0] modelFrame(input logic [31:0] p, input logic corrupt);
    int   s;
    logic [7:0] csum;
    s    = int'(p[31:24]) + int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    csum = 8'(s % 256);
    if (corrupt) csum = csum ^ 8'h01;
    return {p, csum};
  endfunction

  task automatic receiveFrame(input logic [31:0] payload, input logic corrupt,
                              input int changeBit, input int abortBit, input string tag);
    logic [39:0] expBits;
    logic [39:0] gotBits;
    int d, lowLen, hiLen, total, badLow, badHigh, expHigh, expTotal, fdStart, wantHigh;
    expBits = modelFrame(payload, corrupt);
    expHigh = 0;
    for (int b = 0; b < 40; b++) expHigh += expBits[b] ? ONE_HIGH : ZERO_HIGH;
    expTotal = ACK_LOW + ACK_HIGH + 40 * BIT_LOW + expHigh + BIT_LOW;
    setPayload(payload);
`ifdef DHT11_CSUM_INJECT_EN
    bus.i_corrupt_csum = corrupt;
`endif
    fdStart = fdPulses;
    applyStimulus(START_MIN);

    step();
    d = 0;
    while (sample !== 1'b0 && d < 200) begin
      step();
      d++;
    end
    checkOutput({tag, " ack delay"}, 64'(d), 64'(RESP_DELAY + 2));
    checkOutput({tag, " busy in frame"}, 64'(bus.o_busy), 64'd1);
    measure(1'b0, 1000, lowLen);
    checkOutput({tag, " ack low"}, 64'(lowLen), 64'(ACK_LOW));
    measure(1'b1, 1000, hiLen);
    checkOutput({tag, " ack high"}, 64'(hiLen), 64'(ACK_HIGH));

    total   = lowLen + hiLen;
    badLow  = 0;
    badHigh = 0;
    gotBits = '0;
    for (int b = 0; b < 40; b++) begin
      if (b == changeBit) setPayload(32'hAAAAAAAA);
      if (b == abortBit) begin
        repeat (5) step();
        @(negedge clk1mhz);
        rst = 1'b1;
        step();
        checkOutput({tag, " line after reset"}, 64'(sample), 64'd1);
        checkOutput({tag, " busy after reset"}, 64'(bus.o_busy), 64'd0);
        @(negedge clk1mhz);
        rst = 1'b0;
        repeat (100) step();
        checkOutput({tag, " line stays released"}, 64'(sample), 64'd1);
        checkOutput({tag, " no frame_done"}, 64'(fdPulses - fdStart), 64'd0);
        return;
      end
      measure(1'b0, 1000, lowLen);
      if (lowLen != BIT_LOW) badLow++;
      measure(1'b1, 1000, hiLen);
      wantHigh = expBits[39 - b] ? ONE_HIGH : ZERO_HIGH;
      if (hiLen != wantHigh) badHigh++;
      gotBits = {gotBits[38:0], (hiLen > (ZERO_HIGH + ONE_HIGH) / 2)};
      total += lowLen + hiLen;
    end
    measure(1'b0, 1000, lowLen);
    total += lowLen;
    checkOutput({tag, " end low"}, 64'(lowLen), 64'(BIT_LOW));
    checkOutput({tag, " frame_done at release"}, 64'(bus.o_frame_done), 64'd1);
    checkOutput({tag, " busy at release"}, 64'(bus.o_busy), 64'd0);
    checkOutput({tag, " bit low lengths"}, 64'(badLow), 64'd0);
    checkOutput({tag, " bit high lengths"}, 64'(badHigh), 64'd0);
    checkOutput({tag, " frame bits"}, 64'(gotBits), 64'(expBits));
    checkOutput({tag, " checksum"}, 64'(gotBits[7:0]), 64'(expBits[7:0]));
    checkOutput({tag, " frame length"}, 64'(total), 64'(expTotal));
    step();
    checkOutput({tag, " frame_done single"}, 64'(bus.o_frame_done), 64'd0);
    checkOutput({tag, " frame_done count"}, 64'(fdPulses - fdStart), 64'd1);
  endtask

  initial begin
    int bad;
    setPayload(32'h0);
`ifdef DHT11_CSUM_INJECT_EN
    bus.i_corrupt_csum = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk1mhz);
    rst = 1'b0;
    step();
    $display("[TB] reset state");
    checkOutput("reset line", 64'(sample), 64'd1);
    checkOutput("reset busy", 64'(bus.o_busy), 64'd0);
    checkOutput("reset frame_done", 64'(bus.o_frame_done), 64'd0);

    $display("[TB] short host low");
    applyStimulus(SHORT_LOW);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (sample !== 1'b1 || bus.o_busy !== 1'b0) bad++;
    end
    checkOutput("short pulse ignored", 64'(bad), 64'd0);
    checkOutput("short pulse no frame", 64'(fdPulses), 64'd0);

    $display("[TB] directed frames");
    receiveFrame(32'h37001900, 1'b0, -1, -1, "basic");
    receiveFrame(32'hFFFF0102, 1'b0, -1, -1, "csum wrap");
    receiveFrame(32'h5A3C0F81, 1'b0, 10, -1, "latch");
    receiveFrame(32'h01020304, 1'b0, -1, 20, "abort");
    receiveFrame(32'h37001900, 1'b0, -1, -1, "after reset");

    $display("[TB] random frames");
    for (int i = 0; i < 3; i++) receiveFrame($urandom, 1'b0, -1, -1, "random");

`ifdef DHT11_CSUM_INJECT_EN
    $display("[TB] checksum injection");
    receiveFrame(32'h37001900, 1'b1, -1, -1, "inject");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
